// File: rtl/csi2_rx_packet_parser.sv
// CSI-2 receive packet layer: decodes the 4-byte header (ECC checked), streams the
// long-packet payload with a CRC-16 check, and flags short packets and errors.
module csi2_rx_packet_parser #(
  parameter bit          VC_FILTER_EN = 1'b0,
  parameter logic [1:0]  VC_FILTER    = 2'd0,
  parameter logic [15:0] MAX_WC       = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sot,
  input  logic        rx_eot,
  output logic        hdr_valid,
  output logic [1:0]  hdr_vc,
  output logic [5:0]  hdr_dt,
  output logic [15:0] hdr_wc,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        pay_last,
  output logic        pkt_done,
  output logic        ecc_err,
  output logic        crc_err,
  output logic        trunc_err,
  output logic        len_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    CRC     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t      state_r;
  logic [1:0]  hdr_cnt_r;
  logic [7:0]  di_r;
  logic [7:0]  wc_lsb_r;
  logic [7:0]  wc_msb_r;
  logic [7:0]  crc_lo_r;
  logic        crc_hi_r;
  logic [15:0] rem_r;
  logic [15:0] crc_r;

  logic [15:0] wc_s;
  logic [7:0]  ecc_exp_s;
  logic        ecc_ok_s;
  logic        long_s;
  logic        vc_drop_s;
  logic        wc_big_s;
  logic        active_s;
  logic [15:0] crc_next_s;

  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [7:0] p;
    p    = 8'h00;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Header decode terms and the payload CRC step for the current byte
  always_comb begin
    wc_s       = {wc_msb_r, wc_lsb_r};
    ecc_exp_s  = ecc_calc({wc_msb_r, wc_lsb_r, di_r});
    // ecc_exp_s[7:6] is always zero, so a full-byte compare also enforces ECC[7:6] == 0
    ecc_ok_s   = (rx_data == ecc_exp_s);
    long_s     = (di_r[5:0] > 6'h0F);
    vc_drop_s  = VC_FILTER_EN && (di_r[7:6] != VC_FILTER);
    wc_big_s   = ({1'b0, wc_s} > {1'b0, MAX_WC});
    active_s   = (state_r == HDR) || (state_r == PAYLOAD) || (state_r == CRC);
    crc_next_s = crc16_byte(crc_r, rx_data);
  end

  // Packet FSM with registered outputs and one-cycle strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      hdr_cnt_r <= 2'd0;
      di_r      <= 8'h00;
      wc_lsb_r  <= 8'h00;
      wc_msb_r  <= 8'h00;
      crc_lo_r  <= 8'h00;
      crc_hi_r  <= 1'b0;
      rem_r     <= 16'h0000;
      crc_r     <= 16'hFFFF;
      hdr_valid <= 1'b0;
      hdr_vc    <= 2'd0;
      hdr_dt    <= 6'd0;
      hdr_wc    <= 16'h0000;
      pay_data  <= 8'h00;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
      pkt_done  <= 1'b0;
      ecc_err   <= 1'b0;
      crc_err   <= 1'b0;
      trunc_err <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
      pkt_done  <= 1'b0;
      ecc_err   <= 1'b0;
      crc_err   <= 1'b0;
      trunc_err <= 1'b0;
      len_err   <= 1'b0;
      if (rx_valid && rx_sot) begin
        trunc_err <= active_s;
        di_r      <= rx_data;
        hdr_cnt_r <= 2'd1;
        state_r   <= rx_eot ? IDLE : HDR;
      end else begin
        case (state_r)
          IDLE: state_r <= IDLE;
          HDR: begin
            if (rx_valid && (hdr_cnt_r == 2'd3)) begin
              if (!ecc_ok_s) begin
                ecc_err <= 1'b1;
                state_r <= rx_eot ? IDLE : DRAIN;
              end else if (vc_drop_s) begin
                state_r <= rx_eot ? IDLE : DRAIN;
              end else if (long_s && wc_big_s) begin
                len_err <= 1'b1;
                state_r <= rx_eot ? IDLE : DRAIN;
              end else begin
                hdr_valid <= 1'b1;
                hdr_vc    <= di_r[7:6];
                hdr_dt    <= di_r[5:0];
                hdr_wc    <= wc_s;
                crc_r     <= 16'hFFFF;
                rem_r     <= wc_s;
                crc_hi_r  <= 1'b0;
                if (!long_s)              state_r <= IDLE;
                else if (rx_eot) begin
                  trunc_err <= 1'b1;
                  state_r   <= IDLE;
                end
                else if (wc_s == 16'h0000) state_r <= CRC;
                else                       state_r <= PAYLOAD;
              end
            end else begin
              if (rx_valid) begin
                if (hdr_cnt_r == 2'd1) wc_lsb_r <= rx_data;
                else                   wc_msb_r <= rx_data;
                hdr_cnt_r <= hdr_cnt_r + 2'd1;
              end
              if (rx_eot) begin
                trunc_err <= 1'b1;
                state_r   <= IDLE;
              end
            end
          end
          PAYLOAD: begin
            if (rx_valid) begin
              pay_data  <= rx_data;
              pay_valid <= 1'b1;
              crc_r     <= crc_next_s;
              rem_r     <= rem_r - 16'd1;
              if (rem_r == 16'd1) begin
                pay_last <= 1'b1;
                crc_hi_r <= 1'b0;
                state_r  <= CRC;
              end
            end
            // a byte arriving with eot is still streamed before the packet is abandoned
            if (rx_eot) begin
              trunc_err <= 1'b1;
              state_r   <= IDLE;
            end
          end
          CRC: begin
            if (rx_valid && crc_hi_r) begin
              pkt_done <= 1'b1;
              crc_err  <= ({rx_data, crc_lo_r} != crc_r);
              state_r  <= rx_eot ? IDLE : DRAIN;
            end else begin
              if (rx_valid) begin
                crc_lo_r <= rx_data;
                crc_hi_r <= 1'b1;
              end
              if (rx_eot) begin
                trunc_err <= 1'b1;
                state_r   <= IDLE;
              end
            end
          end
          DRAIN: state_r <= rx_eot ? IDLE : DRAIN;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/csi2_rx_packet_parser.md
Name: csi2_rx_packet_parser

Overview:
- Receive-side CSI-2 packet layer, directly downstream of the D-PHY lanes (clk/data0..3 p/n) after the byte/lane merger.
- Consumes one merged byte per clock plus start/end-of-transmission markers.
- Decodes the 4-byte packet header and checks its ECC.
- Streams long-packet payload bytes out, verifies the payload CRC-16, and emits short-packet events.

Parameters:
- VC_FILTER_EN, 0, 1 = drop packets whose VC != VC_FILTER.
- VC_FILTER, 0, 2-bit virtual channel accepted when filtering is on.
- MAX_WC, 16'hFFFF, word counts above this raise len_err and the packet is dropped.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  merged lane byte.
- rx_valid  in  1  rx_data valid this cycle.
- rx_sot  in  1  first byte of a burst; qualified by rx_valid.
- rx_eot  in  1  burst ended; may be asserted without rx_valid.
- hdr_valid  out  1  one-cycle strobe: header accepted.
- hdr_vc  out  2  virtual channel.
- hdr_dt  out  6  data type.
- hdr_wc  out  16  word count (long) or data field (short).
- pay_data  out  8  payload byte.
- pay_valid  out  1  payload byte valid.
- pay_last  out  1  final payload byte.
- pkt_done  out  1  one-cycle strobe at long-packet end.
- ecc_err  out  1  one-cycle strobe: header ECC mismatch.
- crc_err  out  1  one-cycle strobe: payload CRC mismatch.
- trunc_err  out  1  one-cycle strobe: eot before packet completed.
- len_err  out  1  one-cycle strobe: wc > MAX_WC.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, CRC register 16'hFFFF.
- No backpressure. A byte arrives on every rx_valid cycle.
- States: IDLE, HDR, PAYLOAD, CRC, DRAIN.
- IDLE:
  - rx_valid && rx_sot: capture byte 0 (DI), go to HDR.
  - Bytes without sot are ignored.
- HDR:
  - Capture WC LSB, WC MSB, then ECC.
  - On the ECC byte, compare ECC[5:0] with the CSI-2 v1.3 6-bit Hamming ECC over the 24 header bits; ECC[7:6] must be 0.
  - Single-bit errors are not corrected.
  - Mismatch: ecc_err, go to DRAIN.
  - VC filtered out: go to DRAIN silently.
  - wc > MAX_WC (long packets only): len_err, go to DRAIN.
  - Otherwise hdr_valid fires the cycle after the ECC byte.
    - dt <= 6'h0F (short packet): return to IDLE.
    - Long packet, wc == 0: go directly to CRC.
    - Long packet, wc > 0: go to PAYLOAD.
- PAYLOAD:
  - Each input byte appears on pay_data/pay_valid with 1-cycle latency.
  - A 16-bit down-counter tracks remaining bytes; pay_last accompanies the wc-th byte.
  - CRC update: CCITT poly x^16+x^12+x^5+1, reflected form 16'h8408, seed 16'hFFFF, LSB first, no final XOR.
  - After the last byte, go to CRC.
- CRC:
  - Receive CRC LSB, then MSB.
  - pkt_done fires 1 cycle after the MSB.
  - crc_err fires in the same cycle as pkt_done if the received CRC != computed CRC.
  - CRC register reseeds to 16'hFFFF on every new header.
  - Go to DRAIN if rx_eot has not yet been seen, else IDLE.
- DRAIN: discard bytes until rx_eot, then go to IDLE.
- rx_eot in HDR, PAYLOAD or CRC:
  - trunc_err strobe, go to IDLE.
  - No pkt_done; pay_last is not forced.
  - A byte valid in the same cycle as eot is still processed first.
- rx_sot in any non-IDLE state: treated as a new packet start. Abandon the current packet with trunc_err and capture DI.
- Reset asserted mid-packet: outputs clear immediately (async), FSM to IDLE, no error strobes.
- All error strobes are mutually exclusive per packet; at most one per packet.

Test Plan:
- Short packet, bytes 00 00 00 00 (DI=0, WC=0, ECC=00) with sot/eot -> hdr_valid=1, vc=0, dt=0, wc=0; no errors; no pay_valid.
- Same header with ECC byte 01 -> ecc_err=1; no hdr_valid; subsequent bytes ignored until eot.
- Long packet, dt=0x2A, wc=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, CRC bytes F0 00 -> 24 pay_valid, pay_last on the 24th, pkt_done=1, crc_err=0. With CRC bytes F1 00 -> crc_err=1.
- Long packet, wc=10, eot after 5 payload bytes -> 5 pay_valid, trunc_err=1, no pkt_done; next short packet decodes normally.
- VC_FILTER_EN=1, VC_FILTER=1; packet with DI=0x2A (VC 0) -> no outputs. Packet with DI=0x6A (VC 1) -> hdr_valid with vc=1.
- rst_n pulsed low mid-payload -> all outputs 0 within the pulse. A clean packet after release decodes correctly with a fresh CRC seed.
